// File: rtl/unidade_controle_jogo_memoria.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_jogo_memoria
// Description : Moore control unit for the memory-game datapath. It clears and
//               advances the address counter, loads the play register, judges
//               the comparator result and ends the round with pronto plus
//               acertou or errou. Key presses are detected as rising edges of
//               the "any key" level.
//
//               Optional build macro TIMEOUT_EN: adds a cycle counter in ESPERA
//               that ends the round in FIM_TIMEOUT after TIMEOUT_CICLOS cycles
//               without a press. Without it, timeout is tied to 0.
//
// Ports       : clock     - system clock, rising edge
//               reset     - asynchronous, active-low
//               iniciar   - start / restart request (level)
//               jogada    - OR of the key inputs (level)
//               igual     - comparator result
//               fimC      - counter at its last address
//               zeraC     - clear address counter
//               contaC    - increment address counter
//               zeraR     - clear play register
//               registraR - load play register
//               pronto    - round finished
//               acertou   - round won
//               errou     - round lost
//               timeout   - round lost by timeout
//               db_estado - current state code (debug display)
//
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_jogo_memoria #(
    parameter int TIMEOUT_CICLOS  = 3000,
    parameter int LARGURA_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARA     = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0100,
        COMPARA     = 4'b0101,
        PROXIMO     = 4'b0110,
        FIM_ACERTOU = 4'b1010,
        FIM_ERROU   = 4'b1110,
        FIM_TIMEOUT = 4'b1101
    } estado_t;

    // Reject parameter combinations the timeout counter cannot represent.
    if ((TIMEOUT_CICLOS < 2) || (TIMEOUT_CICLOS > 65535) ||
        ((64'd1 << LARGURA_TIMEOUT) <= 64'(TIMEOUT_CICLOS))) begin : g_param_invalido
        $error("unidade_controle_jogo_memoria: invalid TIMEOUT_CICLOS/LARGURA_TIMEOUT");
    end

    estado_t estado_q, estado_d;
    logic    jogada_ant_q, jogada_ant_d;
    logic    pressao;

    // The previous-level register samples in every state, so a key held
    // when ESPERA is entered never looks like a new press.
    assign jogada_ant_d = jogada;
    assign pressao      = jogada & ~jogada_ant_q;

`ifdef TIMEOUT_EN
    localparam logic [LARGURA_TIMEOUT-1:0] LIMITE = LARGURA_TIMEOUT'(TIMEOUT_CICLOS - 1);

    logic [LARGURA_TIMEOUT-1:0] cont_q, cont_d;
    logic                       limite;

    // Zero outside ESPERA, so every entry into ESPERA starts from 0.
    assign cont_d = (estado_q == ESPERA) ? cont_q + 1'b1 : '0;
    assign limite = (cont_q == LIMITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end
`else
    logic limite;
    assign limite = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            jogada_ant_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            jogada_ant_q <= jogada_ant_d;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        estado_d  = INICIAL;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;

        case (estado_q)
            INICIAL: estado_d = iniciar ? PREPARA : INICIAL;
            PREPARA: begin
                zeraC    = 1'b1;
                zeraR    = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A press on the limit cycle wins over the timeout.
                if (pressao) begin
                    estado_d = REGISTRA;
                end else if (limite) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA;
                end
            end
            REGISTRA: begin
                registraR = 1'b1;
                estado_d  = COMPARA;
            end
            COMPARA: begin
                if (!igual) begin
                    estado_d = FIM_ERROU;
                end else if (fimC) begin
                    estado_d = FIM_ACERTOU;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                contaC   = 1'b1;
                estado_d = ESPERA;
            end
            FIM_ACERTOU: begin
                pronto   = 1'b1;
                acertou  = 1'b1;
                estado_d = iniciar ? PREPARA : FIM_ACERTOU;
            end
            FIM_ERROU: begin
                pronto   = 1'b1;
                errou    = 1'b1;
                estado_d = iniciar ? PREPARA : FIM_ERROU;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto   = 1'b1;
                errou    = 1'b1;
                timeout  = 1'b1;
                estado_d = iniciar ? PREPARA : FIM_TIMEOUT;
            end
`endif
            default: estado_d = INICIAL;
        endcase
    end

    assign db_estado = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_jogo_memoria.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_jogo_memoria
// Description : Self-checking bench for unidade_controle_jogo_memoria. A
//               phase-level model of the game predicts every output each cycle;
//               directed rounds are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_jogo_memoria;

    localparam int T = 8;
`ifdef TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    // Model phases of a round
    localparam int F_INI = 0, F_PREP = 1, F_ESP = 2, F_REG = 3, F_CMP = 4,
                   F_PROX = 5, F_ACE = 6, F_ERR = 7, F_TOUT = 8;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada, igual, fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    unidade_controle_jogo_memoria #(
        .TIMEOUT_CICLOS (T),
        .LARGURA_TIMEOUT(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .jogada   (jogada),
        .igual    (igual),
        .fimC     (fimC),
        .zeraC    (zeraC),
        .contaC   (contaC),
        .zeraR    (zeraR),
        .registraR(registraR),
        .pronto   (pronto),
        .acertou  (acertou),
        .errou    (errou),
        .timeout  (timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    int m_fase = F_INI;
    int m_cnt  = 0;
    bit m_prev = 1'b0;

    int n_zc = 0, n_cc = 0, n_rr = 0;

    function automatic logic [11:0] observado();
        return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};
    endfunction

    function automatic logic [11:0] esperado(int f);
        logic [3:0] cod [9];
        cod = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hA, 4'hE, 4'hD};
        return {f == F_PREP, f == F_PROX, f == F_PREP, f == F_REG,
                f >= F_ACE, f == F_ACE, (f == F_ERR) || (f == F_TOUT), f == F_TOUT,
                cod[f]};
    endfunction

    task automatic checa(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelo_reset();
        m_fase = F_INI;
        m_cnt  = 0;
        m_prev = 1'b0;
    endtask

    // One clock: predict from the held inputs, step, then compare everything.
    task automatic ciclo(input string tag);
        int nf;
        bit p;
        logic [11:0] obs;
        nf = m_fase;
        if (!reset) begin
            nf = F_INI;
        end else begin
            p = jogada && !m_prev;
            case (m_fase)
                F_INI:  nf = iniciar ? F_PREP : F_INI;
                F_PREP: nf = F_ESP;
                F_ESP:  nf = p ? F_REG : ((TEN && m_cnt == T - 1) ? F_TOUT : F_ESP);
                F_REG:  nf = F_CMP;
                F_CMP:  nf = !igual ? F_ERR : (fimC ? F_ACE : F_PROX);
                F_PROX: nf = F_ESP;
                default: nf = iniciar ? F_PREP : m_fase;
            endcase
        end
        if (nf == F_ESP && m_fase != F_ESP) m_cnt = 0;
        else if (m_fase == F_ESP)           m_cnt++;
        m_prev = reset ? jogada : 1'b0;
        m_fase = nf;
        @(posedge clock);
        #1;
        obs = observado();
        checa(tag, obs, esperado(m_fase));
        n_zc += int'(zeraC);
        n_cc += int'(contaC);
        n_rr += int'(registraR);
    endtask

    task automatic zera_contagens();
        n_zc = 0; n_cc = 0; n_rr = 0;
    endtask

    task automatic inicia(input string tag);
        iniciar = 1'b1;
        ciclo(tag);
        iniciar = 1'b0;
        ciclo(tag);
    endtask

    // One press: edge, then let REGISTRA/COMPARA/verdict and one more cycle pass.
    task automatic jogar(input string tag, input logic ig, input logic fc);
        igual  = ig;
        fimC   = fc;
        jogada = 1'b1;
        ciclo(tag);
        jogada = 1'b0;
        repeat (3) ciclo(tag);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic reset_meio(input string tag);
        #3;
        reset = 1'b0;
        #1;
        checa(tag, observado(), 12'h000);
        modelo_reset();
        ciclo(tag);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
        modelo_reset();
        @(posedge clock);
        #1;
        checa("reset_inicial", observado(), 12'h000);
        reset = 1'b1;
        repeat (5) ciclo("ocioso");

        // Reset during PREPARA drops zeraC/zeraR without waiting for an edge
        iniciar = 1'b1;
        ciclo("prepara");
        iniciar = 1'b0;
        reset_meio("reset_prepara");
        repeat (2) ciclo("pos_reset");

        // Win of length 4
        zera_contagens();
        inicia("vitoria_ini");
        repeat (3) jogar("vitoria", 1'b1, 1'b0);
        jogar("vitoria", 1'b1, 1'b1);
        checa("vitoria_fim", {8'h0, pronto, acertou, errou, timeout, db_estado} >> 0,
              {8'h0, 4'b1100, 4'b1010});
        checa("vitoria_zera", 12'(n_zc), 12'd1);
        checa("vitoria_registra", 12'(n_rr), 12'd4);
        checa("vitoria_conta", 12'(n_cc), 12'd3);

        // Loss on the 3rd play, then restart without reset
        zera_contagens();
        inicia("derrota_ini");
        repeat (2) jogar("derrota", 1'b1, 1'b0);
        jogar("derrota", 1'b0, 1'b0);
        checa("derrota_fim", {pronto, acertou, errou, timeout, db_estado}, {4'b1010, 4'b1110});
        checa("derrota_conta", 12'(n_cc), 12'd2);
        iniciar = 1'b1;
        ciclo("reinicio");
        checa("reinicio_prepara", {8'h0, db_estado}, 12'h001);
        iniciar = 1'b0;
        ciclo("reinicio");
        checa("reinicio_espera", {8'h0, db_estado}, 12'h002);

        // Held key: one press only until released and pressed again
        zera_contagens();
        igual = 1'b1; fimC = 1'b0; jogada = 1'b1;
        repeat (9) ciclo("tecla_presa");
        checa("tecla_presa_uma", 12'(n_rr), 12'd1);
        jogada = 1'b0;
        ciclo("tecla_solta");
        jogada = 1'b1;
        ciclo("tecla_nova");
        checa("tecla_nova_pulso", 12'(n_rr), 12'd2);
        jogada = 1'b0;
        repeat (3) ciclo("tecla_nova");

        // Reset while in COMPARA
        jogada = 1'b1;
        ciclo("rumo_compara");
        jogada = 1'b0;
        ciclo("rumo_compara");
        checa("em_compara", {8'h0, db_estado}, 12'h005);
        reset_meio("reset_compara");
        repeat (3) ciclo("espera_iniciar");
        checa("apos_reset", {8'h0, db_estado}, 12'h000);

`ifdef TIMEOUT_EN
        inicia("timeout_ini");
        repeat (T) ciclo("timeout");
        checa("timeout_fim", {pronto, acertou, errou, timeout, db_estado}, {4'b1011, 4'b1101});
        inicia("limite_ini");
        repeat (T - 1) ciclo("limite");
        jogada = 1'b1;
        ciclo("limite_pressao");
        checa("limite_registra", {8'h0, db_estado}, 12'h004);
        jogada = 1'b0;
        repeat (3) ciclo("limite");
`else
        inicia("sem_timeout_ini");
        repeat (3 * T) ciclo("sem_timeout");
        checa("sem_timeout_espera", {timeout, 7'h0, db_estado}, 12'h002);
`endif

        // Randomized run
        for (int i = 0; i < 2000; i++) begin
            iniciar = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) jogada = ~jogada;
            igual = ($urandom_range(0, 4) != 0);
            fimC  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) != 0);
            ciclo("aleatorio");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
